// File: rtl/ysyx_22050243_pkg.sv
// Shared definitions for the ysyx_22050243 load/store unit.
//   XLEN        : architectural data width
//   SZ_B..SZ_D  : access-size encodings (byte, half, word, double)
//   lsu_state_e : LSU control FSM states
package ysyx_22050243_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/ysyx_22050243_lsu_align.sv
// Combinational lane logic for the LSU.
//   size_i, is_unsigned_i : access size and load extension mode
//   off_i                 : byte offset within the doubleword
//   wdata_i / wdata_sh_o  : LSB-aligned store data / lane-shifted store data
//   rdata_i / rdata_ext_o : raw doubleword read / extracted, extended load data
//   misalign_o, wmask_o   : alignment fault flag and byte-lane write mask
module ysyx_22050243_lsu_align
  import ysyx_22050243_pkg::*;
(
  input  logic [1:0]      size_i,
  input  logic            is_unsigned_i,
  input  logic [2:0]      off_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic            misalign_o,
  output logic [7:0]      wmask_o,
  output logic [XLEN-1:0] wdata_sh_o,
  output logic [XLEN-1:0] rdata_ext_o
);

  logic [5:0]      bit_off;
  logic [7:0]      mask_base;
  logic [XLEN-1:0] rsh;

  always_comb begin
    bit_off     = {off_i, 3'b000};
    rsh         = rdata_i >> bit_off;
    wdata_sh_o  = wdata_i << bit_off;
    misalign_o  = 1'b0;
    mask_base   = 8'h00;
    rdata_ext_o = '0;
    unique case (size_i)
      SZ_B: begin
        misalign_o  = 1'b0;
        mask_base   = 8'h01;
        rdata_ext_o = {{56{rsh[7] & ~is_unsigned_i}}, rsh[7:0]};
      end
      SZ_H: begin
        misalign_o  = off_i[0];
        mask_base   = 8'h03;
        rdata_ext_o = {{48{rsh[15] & ~is_unsigned_i}}, rsh[15:0]};
      end
      SZ_W: begin
        misalign_o  = |off_i[1:0];
        mask_base   = 8'h0F;
        rdata_ext_o = {{32{rsh[31] & ~is_unsigned_i}}, rsh[31:0]};
      end
      SZ_D: begin
        misalign_o  = |off_i;
        mask_base   = 8'hFF;
        rdata_ext_o = rsh;
      end
      default: ;
    endcase
    // Aligned accesses never carry mask bits past lane 7, so truncation is safe.
    wmask_o = mask_base << off_i;
  end

endmodule

// File: rtl/ysyx_22050243_lsu.sv
// Load/store unit: accepts one request at a time, issues a single
// doubleword-aligned memory access, and returns extended load data.
//   clk, rst                  : clock, asynchronous active-high reset
//   req_*                     : request handshake and payload from execute
//   resp_*                    : response handshake and payload to writeback
//   data_*                    : data-memory port (read combinational, write at posedge)
module ysyx_22050243_lsu
  import ysyx_22050243_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misalign,
  output logic              data_r_en,
  output logic              data_w_en,
  output logic [7:0]        data_wmask,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_w,
  input  logic [DATA_W-1:0] data_r
);

  lsu_state_e        state_q, state_d;
  logic              wen_q, wen_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mis_q, mis_d;

  logic              is_idle;
  logic [1:0]        al_size;
  logic [2:0]        al_off;
  logic              al_misalign;
  logic [7:0]        al_wmask;
  logic [DATA_W-1:0] al_wdata_sh;
  logic [DATA_W-1:0] al_rdata_ext;

  // In IDLE the aligner checks the incoming request; afterwards it sees the latched one.
  assign is_idle = (state_q == StIdle);
  assign al_size = is_idle ? req_size : size_q;
  assign al_off  = is_idle ? req_addr[2:0] : addr_q[2:0];

  ysyx_22050243_lsu_align u_align (
    .size_i        (al_size),
    .is_unsigned_i (uns_q),
    .off_i         (al_off),
    .wdata_i       (wdata_q),
    .rdata_i       (data_r),
    .misalign_o    (al_misalign),
    .wmask_o       (al_wmask),
    .wdata_sh_o    (al_wdata_sh),
    .rdata_ext_o   (al_rdata_ext)
  );

  always_comb begin
    state_d    = state_q;
    wen_d      = wen_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    mis_d      = mis_q;
    req_ready  = is_idle && !rst;
    resp_valid = (state_q == StResp);
    data_r_en  = 1'b0;
    data_w_en  = 1'b0;
    data_wmask = 8'h00;
    data_addr  = '0;
    data_w     = '0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          wen_d   = req_wen;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          mis_d   = al_misalign;
          state_d = al_misalign ? StResp : StAccess;
        end
      end
      StAccess: begin
        data_addr = {addr_q[ADDR_W-1:3], 3'b000};
        data_r_en = !wen_q;
        data_w_en = wen_q;
        if (wen_q) begin
          data_wmask = al_wmask;
          data_w     = al_wdata_sh;
        end
        rdata_d = wen_q ? '0 : al_rdata_ext;
        mis_d   = 1'b0;
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready) begin
          rdata_d = '0;
          mis_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign resp_rdata    = rdata_q;
  assign resp_misalign = mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wen_q   <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
module tb_ysyx_22050243_lsu;

  typedef struct packed {
    logic [63:0] rdata;
    logic        mis;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_rdata;
  logic        resp_misalign;
  logic        data_r_en;
  logic        data_w_en;
  logic [7:0]  data_wmask;
  logic [63:0] data_addr;
  logic [63:0] data_w;
  logic [63:0] data_r;

  logic [63:0] mem [16];
  logic        mem_load = 1'b1;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  resp_t       sb [$];

  always #5 clk = ~clk;

  ysyx_22050243_lsu dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wen       (req_wen),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign),
    .data_r_en     (data_r_en),
    .data_w_en     (data_w_en),
    .data_wmask    (data_wmask),
    .data_addr     (data_addr),
    .data_w        (data_w),
    .data_r        (data_r)
  );

  // Memory model: 16 doublewords at 0x8000_0000, masked write at posedge.
  assign data_r = data_r_en ? mem[data_addr[6:3]] : 64'h0;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= 64'h0;
      mem[0] <= 64'h1122_3344_8899_AABB;
      mem[1] <= 64'h0102_0304_0506_0708;
    end else if (data_w_en) begin
      for (int i = 0; i < 8; i++)
        if (data_wmask[i]) mem[data_addr[6:3]][8*i +: 8] <= data_w[8*i +: 8];
    end
    if (data_r_en) rd_cnt <= rd_cnt + 1;
    if (data_w_en) wr_cnt <= wr_cnt + 1;
    if (data_r_en && data_w_en) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Issue one request (called at posedge+1) and run it to completion with resp_ready high.
  task automatic do_req(input string tag, input logic wen, input logic [1:0] size,
                        input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] exp_rdata, input logic exp_mis,
                        input logic [7:0] exp_mask, input logic [63:0] exp_w);
    int    rd0;
    int    wr0;
    int    lat;
    resp_t exp;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    sb.push_back('{rdata: exp_rdata, mis: exp_mis});
    req_valid    = 1'b1;
    req_wen      = wen;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    chk({tag, "_req_ready"}, {63'h0, req_ready}, 64'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!exp_mis) begin
      chk({tag, "_acc_addr"}, data_addr, {addr[63:3], 3'b000});
      chk({tag, "_acc_en"}, {62'h0, data_r_en, data_w_en}, {62'h0, !wen, wen});
      if (wen) begin
        chk({tag, "_acc_mask"}, {56'h0, data_wmask}, {56'h0, exp_mask});
        chk({tag, "_acc_w"}, data_w, exp_w);
      end
      @(posedge clk); #1;
    end
    lat = 0;
    while (!resp_valid && lat < 4) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_resp_latency"}, 64'(lat), 64'h0);
    exp = sb.pop_front();
    chk({tag, "_rdata"}, resp_rdata, exp.rdata);
    chk({tag, "_misalign"}, {63'h0, resp_misalign}, {63'h0, exp.mis});
    chk({tag, "_rd_cnt"}, 64'(rd_cnt - rd0), 64'((!wen && !exp_mis) ? 1 : 0));
    chk({tag, "_wr_cnt"}, 64'(wr_cnt - wr0), 64'((wen && !exp_mis) ? 1 : 0));
    @(posedge clk); #1;
    chk({tag, "_done"}, {62'h0, resp_valid, req_ready}, 64'h1);
  endtask

  initial begin
    logic [63:0] hold;
    // Reset state
    #1;
    chk("rst_req_ready", {63'h0, req_ready}, 64'h0);
    chk("rst_resp", {62'h0, resp_valid, resp_misalign}, 64'h0);
    chk("rst_rdata", resp_rdata, 64'h0);
    chk("rst_mem_ctl", {54'h0, data_r_en, data_w_en, data_wmask}, 64'h0);
    chk("rst_mem_addr", data_addr, 64'h0);
    chk("rst_mem_w", data_w, 64'h0);
    @(posedge clk); @(posedge clk); #1;
    mem_load = 1'b0;
    rst      = 1'b0;
    #1;
    chk("post_rst_ready", {63'h0, req_ready}, 64'h1);
    @(posedge clk); #1;

    // Loads from 0x1122_3344_8899_AABB
    do_req("ld_h_s", 1'b0, 2'd1, 1'b0, 64'h8000_0002, 64'h0,
           64'hFFFF_FFFF_FFFF_8899, 1'b0, 8'h00, 64'h0);
    do_req("ld_h_u", 1'b0, 2'd1, 1'b1, 64'h8000_0002, 64'h0,
           64'h0000_0000_0000_8899, 1'b0, 8'h00, 64'h0);
    do_req("ld_w_u", 1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'h0,
           64'h0000_0000_1122_3344, 1'b0, 8'h00, 64'h0);
    do_req("ld_d", 1'b0, 2'd3, 1'b0, 64'h8000_0000, 64'h0,
           64'h1122_3344_8899_AABB, 1'b0, 8'h00, 64'h0);
    do_req("ld_b_s", 1'b0, 2'd0, 1'b0, 64'h8000_0001, 64'h0,
           64'hFFFF_FFFF_FFFF_FFAA, 1'b0, 8'h00, 64'h0);
    do_req("ld_w_s", 1'b0, 2'd2, 1'b0, 64'h8000_0000, 64'h0,
           64'hFFFF_FFFF_8899_AABB, 1'b0, 8'h00, 64'h0);

    // Misaligned requests: no access, response one cycle after accept
    do_req("ld_w_mis", 1'b0, 2'd2, 1'b0, 64'h8000_0006, 64'h0,
           64'h0, 1'b1, 8'h00, 64'h0);
    do_req("st_h_mis", 1'b1, 2'd1, 1'b0, 64'h8000_0001, 64'hFFFF,
           64'h0, 1'b1, 8'h00, 64'h0);
    chk("st_h_mis_mem", mem[0], 64'h1122_3344_8899_AABB);

    // Stores
    do_req("st_b", 1'b1, 2'd0, 1'b0, 64'h8000_0003, 64'h0000_0000_0000_00AB,
           64'h0, 1'b0, 8'h08, 64'h0000_0000_AB00_0000);
    chk("st_b_mem", mem[0], 64'h1122_3344_AB99_AABB);
    do_req("st_h", 1'b1, 2'd1, 1'b0, 64'h8000_0016, 64'hFFFF_FFFF_FFFF_BEEF,
           64'h0, 1'b0, 8'hC0, 64'hBEEF_0000_0000_0000);
    chk("st_h_mem", mem[2], 64'hBEEF_0000_0000_0000);
    do_req("ld_b_u", 1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'h0,
           64'h0000_0000_0000_00AB, 1'b0, 8'h00, 64'h0);

    // Backpressure: response held, competing request ignored
    resp_ready = 1'b0;
    hold       = rd_cnt;
    sb.push_back('{rdata: 64'h0102_0304_0506_0708, mis: 1'b0});
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr  = 64'h8000_0008;
    @(posedge clk); #1;
    req_addr = 64'h8000_0000;  // stays valid throughout RESP
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_%0d", i), {62'h0, resp_valid, req_ready}, 64'h2);
      chk($sformatf("bp_rdata_%0d", i), resp_rdata, sb[0].rdata);
      @(posedge clk); #1;
    end
    chk("bp_rd_cnt", 64'(rd_cnt) - hold, 64'h1);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    begin
      resp_t exp;
      exp = sb.pop_front();
      chk("bp_final_rdata", resp_rdata, exp.rdata);
    end
    @(posedge clk); #1;
    chk("bp_done", {62'h0, resp_valid, req_ready}, 64'h1);

    // Reset during a store ACCESS
    hold = wr_cnt;
    req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd3;
    req_addr  = 64'h8000_0008; req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_acc_wen_before", {63'h0, data_w_en}, 64'h1);
    chk("rst_acc_w_before", data_w, 64'hDEAD_BEEF_CAFE_F00D);
    rst = 1'b1;
    #1;
    chk("rst_acc_wen_after", {63'h0, data_w_en}, 64'h0);
    chk("rst_acc_mask_after", {56'h0, data_wmask}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_acc_mem", mem[1], 64'h0102_0304_0506_0708);
    chk("rst_acc_wr_cnt", 64'(wr_cnt) - hold, 64'h0);
    chk("rst_acc_ready", {62'h0, resp_valid, req_ready}, 64'h1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_acc_no_resp_%0d", i), {63'h0, resp_valid}, 64'h0);
    end

    do_req("ld_after_rst", 1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'h0,
           64'h0102_0304_0506_0708, 1'b0, 8'h00, 64'h0);
    chk("never_both_en", 64'(both_cnt), 64'h0);
    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
